// File: rtl/mobo_xfer_engine_pkg.sv
// Shared mobo handshake encodings, engine FSM states and a state-name helper
// for debug displays.
package mobo_xfer_engine_pkg;

    localparam int CTRL_NONE  = 0;
    localparam int CTRL_READ  = 1;
    localparam int CTRL_WRITE = 2;

    localparam int MOBO_IDLE  = 0;
    localparam int MOBO_BUSY  = 1;
    localparam int MOBO_DONE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Fixed nine-character ASCII name, usable from waveform viewers and benches.
    function automatic logic [71:0] state_name(input state_t s);
        case (s)
            ST_IDLE:  return "IDLE     ";
            ST_LOAD:  return "LOAD     ";
            ST_ISSUE: return "ISSUE    ";
            default:  return "WAIT_DONE";
        endcase
    endfunction

endpackage

// File: rtl/mobo_xfer_engine_sync_fifo.sv
// Request queue for the transfer engine: single-clock FIFO with full/empty
// flags and a show-ahead read port.
module mobo_xfer_engine_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mobo_xfer_engine.sv
// Queued bus-master engine running the mobo_ctrl/mobo_stat handshake per beat.
// Optional watchdog abort: define MOBO_XFER_TIMEOUT_EN.
module mobo_xfer_engine
    import mobo_xfer_engine_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_BURST      = 8,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    input  logic [LEN_W-1:0]      req_len,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [WORD_WIDTH-1:0] mobo_ctrl,
    input  logic [WORD_WIDTH-1:0] mobo_stat,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [WORD_WIDTH-1:0] mobodat_out,
    input  logic [WORD_WIDTH-1:0] mobodat_in
);
    typedef struct packed {
        logic                  write;
        logic [LEN_W-1:0]      len;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] wdata;
    } req_t;

    req_t             q_in;
    req_t             q_out;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    state_t           state;
    logic             op_write;
    logic [LEN_W-1:0] beats;
    logic [LEN_W-1:0] eff_len;
    logic             stat_idle;
    logic             stat_done;

    assign req_ready = rst && !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ST_LOAD);
    assign q_in      = '{write: req_write, len: req_len, addr: req_addr, wdata: req_wdata};
    assign busy      = !empty || (state != ST_IDLE);
    assign stat_idle = (mobo_stat == WORD_WIDTH'(MOBO_IDLE));
    assign stat_done = (mobo_stat == WORD_WIDTH'(MOBO_DONE));

    // Writes are single-beat; zero-length reads still move one word.
    assign eff_len = (q_out.write || q_out.len == '0) ? LEN_W'(1) :
                     (q_out.len > LEN_W'(MAX_BURST))  ? LEN_W'(MAX_BURST) : q_out.len;

    mobo_xfer_engine_sync_fifo #(
        .WIDTH($bits(req_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (q_in),
        .dout (q_out),
        .full (full),
        .empty(empty)
    );

`ifdef MOBO_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        prev_state;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cur;
    logic          tmo_hit;

    // Count restarts on the first cycle of every newly entered state.
    assign tmo_cur = (state != prev_state) ? '0 : tmo_cnt;
    assign tmo_hit = (state == ST_ISSUE || state == ST_WAIT_DONE) &&
                     (tmo_cur == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_state <= ST_IDLE;
            tmo_cnt    <= '0;
        end else begin
            prev_state <= state;
            tmo_cnt    <= tmo_cur + 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mobo_ctrl   <= WORD_WIDTH'(CTRL_NONE);
            addr_out    <= '0;
            mobodat_out <= '0;
            rsp_data    <= '0;
            beats       <= '0;
            op_write    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_last    <= 1'b0;
`ifdef MOBO_XFER_TIMEOUT_EN
            rsp_err     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
`ifdef MOBO_XFER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            // A DONE arriving on the expiry edge still completes the beat normally.
            if (tmo_hit && !(state == ST_WAIT_DONE && stat_done)) begin
                mobo_ctrl <= WORD_WIDTH'(CTRL_NONE);
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_last  <= 1'b1;
                rsp_data  <= '0;
                state     <= ST_IDLE;
            end else
`endif
            case (state)
                // Looking at the incoming push saves a cycle on an empty queue.
                ST_IDLE: if (!empty || push) state <= ST_LOAD;
                ST_LOAD: begin
                    op_write    <= q_out.write;
                    addr_out    <= q_out.addr;
                    mobodat_out <= q_out.wdata;
                    beats       <= eff_len;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: if (stat_idle) begin
                    mobo_ctrl <= op_write ? WORD_WIDTH'(CTRL_WRITE) : WORD_WIDTH'(CTRL_READ);
                    state     <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (stat_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= op_write ? '0 : mobodat_in;
                        rsp_last  <= (beats == LEN_W'(1));
                        mobo_ctrl <= WORD_WIDTH'(CTRL_NONE);
                        if (beats > LEN_W'(1)) begin
                            beats    <= beats - 1'b1;
                            addr_out <= addr_out + 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!stat_idle) begin
                        mobo_ctrl <= WORD_WIDTH'(CTRL_NONE);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
